// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response, execute redirect and decoder
// handoff. The master modport is the fetch unit; the slave modport is its environment.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;
  logic        fetch_fault;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, instr_pc4, fetch_fault,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_target,
           instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, instr_pc4, fetch_fault,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_target,
           instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32 fetch stage: owns the PC, keeps one imem request in flight and buffers words in a FIFO.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets with a sticky fetch_fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [31:0] Nop  = 32'h0000_0013;

  typedef enum logic [1:0] {StReq, StWait, StDrop} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [31:0]     data_q [FIFO_DEPTH];
  logic [31:0]     data_d [FIFO_DEPTH];
  logic [31:0]     pc_q [FIFO_DEPTH];
  logic [31:0]     pc_d [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic        outstanding, resp, not_empty, head_valid, pop, push;
  logic        req_valid, accept, blocked, misalign;
  logic [31:0] occupancy, target;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;

  assign misalign = bus.redirect_valid & (|bus.redirect_target[1:0]);
  assign target   = bus.redirect_target;
  assign blocked  = fault_q;
  assign bus.fetch_fault = fault_q;
`else
  logic unused_tgt_lsb;

  assign unused_tgt_lsb  = ^bus.redirect_target[1:0];
  assign misalign        = 1'b0;
  assign target          = {bus.redirect_target[31:2], 2'b00};
  assign blocked         = 1'b0;
  assign bus.fetch_fault = 1'b0;
`endif

  always_comb begin
    outstanding = (state_q != StReq);
    resp        = outstanding & bus.imem_resp_valid;
    not_empty   = (count_q != '0);
    head_valid  = not_empty & ~bus.redirect_valid;
    pop         = head_valid & bus.instr_ready;
    // Slot reserved for the in-flight word keeps the FIFO from ever overflowing.
    occupancy   = 32'(count_q) + 32'(outstanding) - 32'(pop);
    req_valid   = (state_q != StDrop) & ~(outstanding & ~resp) & (occupancy < FIFO_DEPTH)
                & ~bus.redirect_valid & ~blocked;
    accept      = req_valid & bus.imem_req_ready;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_d    = fault_q | misalign;
`endif
    if (accept) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    unique case (state_q)
      StReq: begin
        if (accept) state_d = StWait;
      end
      StWait: begin
        if (bus.redirect_valid) begin
          state_d = resp ? StReq : StDrop;
        end else if (resp) begin
          push    = 1'b1;
          state_d = accept ? StWait : StReq;
        end
      end
      StDrop: begin
        if (resp) state_d = StReq;
      end
      default: state_d = StReq;
    endcase
    if (bus.redirect_valid) fetch_pc_d = target;
  end

  always_comb begin
    data_d   = data_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.redirect_valid | misalign) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = bus.imem_resp_data;
        pc_d[wr_ptr_q]   = req_pc_q;
        wr_ptr_d         = wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StReq;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q    <= fault_d;
`endif
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.instr_valid    = head_valid;
  assign bus.instr          = not_empty ? data_q[rd_ptr_q] : Nop;
  assign bus.instr_pc       = not_empty ? pc_q[rd_ptr_q] : 32'd0;
  assign bus.instr_pc4      = not_empty ? pc_q[rd_ptr_q] + 32'd4 : 32'd0;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable in-order imem model returns
// addr + 0x1000_0000 as the instruction word for each accepted request.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int lat   = 1;

  logic        m_busy;
  int          m_cnt;
  logic        m_resp_v;
  logic [31:0] m_data;

  assign bus.imem_resp_valid = m_resp_v;
  assign bus.imem_resp_data  = m_data;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy   <= 1'b0;
      m_cnt    <= 0;
      m_resp_v <= 1'b0;
      m_data   <= '0;
    end else begin
      m_resp_v <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 1) begin
          m_resp_v <= 1'b1;
          m_busy   <= 1'b0;
        end
        m_cnt <= m_cnt - 1;
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        m_data <= bus.imem_req_addr + 32'h1000_0000;
        if (lat == 1) m_resp_v <= 1'b1;
        else begin
          m_busy <= 1'b1;
          m_cnt  <= lat - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_instr(input int budget);
    int n = 0;
    while (bus.instr_valid !== 1'b1 && n < budget) begin
      nxt();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset = 1'b1;
    bus.imem_req_ready  = 1'b1;
    bus.instr_ready     = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    lat = 1;
    @(posedge clk);
    #2;
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'h0000_0013);
    chk("rst_instr_pc", bus.instr_pc, 32'd0);
    chk("rst_instr_pc4", bus.instr_pc4, 32'd0);
    chk("rst_fault", 32'(bus.fetch_fault), 32'd0);
    chk("rst_addr", bus.imem_req_addr, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;

    // 1: streaming with 1-cycle memory
    chk("t1_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t1_addr0", bus.imem_req_addr, 32'h0);
    nxt();
    chk("t1_addr4", bus.imem_req_addr, 32'h4);
    chk("t1_no_valid_yet", 32'(bus.instr_valid), 32'd0);
    nxt();
    chk("t1_first_valid", 32'(bus.instr_valid), 32'd1);
    chk("t1_pc0", bus.instr_pc, 32'h0);
    chk("t1_pc4_0", bus.instr_pc4, 32'h4);
    chk("t1_instr0", bus.instr, 32'h1000_0000);
    chk("t1_addr8", bus.imem_req_addr, 32'h8);
    nxt();
    chk("t1_pc1", bus.instr_pc, 32'h4);
    chk("t1_pc4_1", bus.instr_pc4, 32'h8);
    chk("t1_addrC", bus.imem_req_addr, 32'hC);
    nxt();
    chk("t1_pc2", bus.instr_pc, 32'h8);
    chk("t1_pc4_2", bus.instr_pc4, 32'hC);

    // 2: decoder stall fills the buffer
    bus.instr_ready = 1'b0;
    do_reset();
    nxt();
    nxt();
    chk("t2_full_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("t2_head0", bus.instr_pc, 32'h0);
    nxt();
    chk("t2_held_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("t2_held_addr", bus.imem_req_addr, 32'h8);
    nxt();
    chk("t2_still_blocked", 32'(bus.imem_req_valid), 32'd0);
    bus.instr_ready = 1'b1;
    #1;
    chk("t2_resume_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t2_resume_addr", bus.imem_req_addr, 32'h8);
    chk("t2_pop0", bus.instr_pc, 32'h0);
    nxt();
    chk("t2_pop4", bus.instr_pc, 32'h4);
    chk("t2_addrC", bus.imem_req_addr, 32'hC);
    nxt();
    chk("t2_pop8", bus.instr_pc, 32'h8);
    chk("t2_instr8", bus.instr, 32'h1000_0008);

    // 3: memory back-pressure
    bus.imem_req_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("t3_hold_addr", bus.imem_req_addr, 32'h0);
      nxt();
    end
    bus.imem_req_ready = 1'b1;
    #1;
    chk("t3_c6_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t3_c6_addr", bus.imem_req_addr, 32'h0);
    nxt();
    chk("t3_after_accept", bus.imem_req_addr, 32'h4);
    chk("t3_no_instr", 32'(bus.instr_valid), 32'd0);
    nxt();
    chk("t3_instr_valid", 32'(bus.instr_valid), 32'd1);
    chk("t3_instr_pc", bus.instr_pc, 32'h0);

    // 4: redirect while waiting on a 3-cycle memory
    lat = 3;
    do_reset();
    chk("t4_addr0", bus.imem_req_addr, 32'h0);
    nxt();
    chk("t4_wait_no_req", 32'(bus.imem_req_valid), 32'd0);
    nxt();
    nxt();
    chk("t4_req4_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t4_req4_addr", bus.imem_req_addr, 32'h4);
    nxt();
    chk("t4_pc0", bus.instr_pc, 32'h0);
    nxt();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h100;
    #1;
    chk("t4_redir_no_req", 32'(bus.imem_req_valid), 32'd0);
    chk("t4_redir_mask", 32'(bus.instr_valid), 32'd0);
    nxt();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t4_drop_no_req", 32'(bus.imem_req_valid), 32'd0);
    nxt();
    chk("t4_new_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t4_new_req_addr", bus.imem_req_addr, 32'h100);
    wait_instr(12);
    chk("t4_instr_valid", 32'(bus.instr_valid), 32'd1);
    chk("t4_instr_pc", bus.instr_pc, 32'h100);
    chk("t4_instr", bus.instr, 32'h1000_0100);

    // 5: redirect coincides with a response, buffer holds one entry
    lat = 1;
    bus.instr_ready = 1'b0;
    do_reset();
    nxt();
    nxt();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h200;
    #1;
    chk("t5_redir_mask", 32'(bus.instr_valid), 32'd0);
    chk("t5_redir_no_req", 32'(bus.imem_req_valid), 32'd0);
    nxt();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t5_flushed", 32'(bus.instr_valid), 32'd0);
    chk("t5_nop", bus.instr, 32'h0000_0013);
    chk("t5_pc_empty", bus.instr_pc, 32'h0);
    chk("t5_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t5_req_addr", bus.imem_req_addr, 32'h200);
    bus.instr_ready = 1'b1;
    wait_instr(8);
    chk("t5_instr_valid", 32'(bus.instr_valid), 32'd1);
    chk("t5_instr_pc", bus.instr_pc, 32'h200);

    // 6: misaligned redirect target
    do_reset();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h102;
    #1;
    chk("t6_redir_no_req", 32'(bus.imem_req_valid), 32'd0);
    nxt();
    bus.redirect_valid = 1'b0;
    #1;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("t6_fault", 32'(bus.fetch_fault), 32'd1);
    chk("t6_blocked", 32'(bus.imem_req_valid), 32'd0);
    nxt();
    nxt();
    chk("t6_still_blocked", 32'(bus.imem_req_valid), 32'd0);
    chk("t6_no_instr", 32'(bus.instr_valid), 32'd0);
    chk("t6_fault_sticky", 32'(bus.fetch_fault), 32'd1);
`else
    chk("t6_no_fault", 32'(bus.fetch_fault), 32'd0);
    chk("t6_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t6_aligned_addr", bus.imem_req_addr, 32'h100);
    wait_instr(8);
    chk("t6_instr_valid", 32'(bus.instr_valid), 32'd1);
    chk("t6_instr_pc", bus.instr_pc, 32'h100);
`endif

    // 7: PC wraps at the top of the address space
    do_reset();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    #1;
    nxt();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t7_top_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t7_top_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    nxt();
    chk("t7_wrap_addr", bus.imem_req_addr, 32'h0);
    nxt();
    chk("t7_top_pc", bus.instr_pc, 32'hFFFF_FFFC);
    chk("t7_top_pc4", bus.instr_pc4, 32'h0);
    chk("t7_top_instr", bus.instr, 32'h0FFF_FFFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
